// File: rtl/trap_unit_pkg.sv
// trap_unit_pkg: shared definitions for the machine-mode trap unit.
//   - mcause encodings for the synchronous traps and the external interrupt
//   - addresses of the CSRs owned by the trap unit
//   - bit positions inside mstatus / mie / mip
//   - privilege encodings and the trap FSM state type
// Optional feature macro used elsewhere: TRAP_UNIT_VECTORED_EN.
package trap_unit_pkg;

  localparam logic [31:0] CAUSE_ILLEGAL          = 32'd1;
  localparam logic [31:0] CAUSE_CSR_VIOLATION    = 32'd2;
  localparam logic [31:0] CAUSE_INSTR_MISALIGNED = 32'd3;
  localparam logic [31:0] CAUSE_LS_MISALIGNED    = 32'd4;
  localparam logic [31:0] CAUSE_MEXT_IRQ         = 32'h8000_000B;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MEIE       = 11;
  localparam int MIP_MEIP       = 11;

  // Byte offset of the machine external interrupt entry in vectored mode (4 * 11).
  localparam int IRQ_VECTOR_OFFSET = 44;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ENTER_FLUSH,
    RET_FLUSH
  } state_t;

endpackage

// File: rtl/trap_unit_if.sv
// trap_unit_if: CSR access port between the csr block (master) and the
// trap unit (slave).
//   csr_we    - write strobe
//   csr_addr  - 12-bit CSR address
//   csr_wdata - write data
//   csr_rdata - combinational read data, 0 for addresses the slave does not own
//   csr_hit   - the slave owns csr_addr
interface trap_unit_if #(
  parameter int XLEN = 32
);
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_hit;

  modport master (output csr_we, csr_addr, csr_wdata, input csr_rdata, csr_hit);
  modport slave  (input csr_we, csr_addr, csr_wdata, output csr_rdata, csr_hit);
endinterface

// File: rtl/trap_unit_prio_enc.sv
// trap_prio_enc: combinational priority encoder for trap sources.
//   inputs : four synchronous trap flags, irq_pending (already masked by MIE/MEIE)
//   outputs: take_trap (any source active), is_irq (winner is the interrupt),
//            cause (mcause value of the winner, 0 when nothing is taken)
// Priority high to low: illegal, CSR violation, fetch misaligned,
// load/store misaligned, external interrupt.
module trap_prio_enc
  import trap_unit_pkg::*;
(
  input  logic        illegal_instr,
  input  logic        csr_access_violation,
  input  logic        instr_addr_misaligned,
  input  logic        load_store_misaligned,
  input  logic        irq_pending,
  output logic        take_trap,
  output logic        is_irq,
  output logic [31:0] cause
);

  always_comb begin
    take_trap = 1'b1;
    is_irq    = 1'b0;
    cause     = '0;
    if (illegal_instr) begin
      cause = CAUSE_ILLEGAL;
    end else if (csr_access_violation) begin
      cause = CAUSE_CSR_VIOLATION;
    end else if (instr_addr_misaligned) begin
      cause = CAUSE_INSTR_MISALIGNED;
    end else if (load_store_misaligned) begin
      cause = CAUSE_LS_MISALIGNED;
    end else if (irq_pending) begin
      is_irq = 1'b1;
      cause  = CAUSE_MEXT_IRQ;
    end else begin
      take_trap = 1'b0;
    end
  end

endmodule

// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap entry / mret return and owner of the M-mode
// trap CSRs (mstatus, mie, mtvec, mepc, mcause, mtval, mip).
//   clk, reset_n            - clock, asynchronous active-low reset
//   trap_* / trap_pc/tval   - synchronous trap flags and their PC / tval
//   gpio0_irq, gpio1_irq    - level-sensitive external interrupts
//   irq_pc                  - resume point used as mepc for interrupts
//   mret_valid              - qualified mret in EX
//   csr (trap_unit_if.slave)- CSR read/write port
//   flush_trap, redirect_*  - one-cycle flush and PC redirect
//   privilege               - current privilege level
// Optional feature: define TRAP_UNIT_VECTORED_EN to make mtvec[1:0] writable
// and send interrupts to base + 44 when mtvec mode is 2'b01.
module trap_unit
  import trap_unit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            trap_illegal_instr,
  input  logic            trap_csr_access_violation,
  input  logic            trap_instr_addr_misaligned,
  input  logic            trap_load_store_misaligned,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            gpio0_irq,
  input  logic            gpio1_irq,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            mret_valid,
  trap_unit_if.slave      csr,
  output logic            flush_trap,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      privilege
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t state, next_state;

  logic            mstatus_mie, mstatus_mpie;
  logic [1:0]      mstatus_mpp;
  logic            mie_meie;
  logic [XLEN-1:0] mtvec, mepc, mcause, mtval;

  logic        meip, irq_pending, take_trap, is_irq;
  logic [31:0] cause;
  logic        do_entry, do_mret;
  logic [XLEN-1:0] handler_base;

  assign meip        = gpio0_irq | gpio1_irq;
  assign irq_pending = mstatus_mie & mie_meie & meip;

  trap_prio_enc u_prio (
    .illegal_instr         (trap_illegal_instr),
    .csr_access_violation  (trap_csr_access_violation),
    .instr_addr_misaligned (trap_instr_addr_misaligned),
    .load_store_misaligned (trap_load_store_misaligned),
    .irq_pending           (irq_pending),
    .take_trap             (take_trap),
    .is_irq                (is_irq),
    .cause                 (cause)
  );

  assign handler_base = mtvec & ALIGN_MASK;

  // Trap FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next state, entry/return events and the flush/redirect outputs. Events are
  // only recognised in IDLE; in the flush states they belong to squashed
  // instructions. Redirect outputs depend on state alone so reset clears them
  // without a clock edge.
  always_comb begin
    next_state     = IDLE;
    do_entry       = 1'b0;
    do_mret        = 1'b0;
    flush_trap     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      IDLE: begin
        if (take_trap) begin
          do_entry   = 1'b1;
          next_state = ENTER_FLUSH;
        end else if (mret_valid) begin
          do_mret    = 1'b1;
          next_state = RET_FLUSH;
        end
      end
      ENTER_FLUSH: begin
        flush_trap     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = handler_base;
`ifdef TRAP_UNIT_VECTORED_EN
        // mcause was written at entry, so its MSB tells us this was an interrupt.
        if (mtvec[1:0] == 2'b01 && mcause[XLEN-1])
          redirect_pc = handler_base + XLEN'(IRQ_VECTOR_OFFSET);
`endif
      end
      RET_FLUSH: begin
        flush_trap     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = mepc;
      end
      default: next_state = IDLE;
    endcase
  end

  // CSR state: trap entry and mret take precedence and swallow any CSR write
  // issued in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      privilege    <= PRIV_M;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mstatus_mpp  <= PRIV_U;
      mie_meie     <= 1'b0;
`ifdef TRAP_UNIT_VECTORED_EN
      mtvec        <= RESET_MTVEC;
`else
      mtvec        <= RESET_MTVEC & ALIGN_MASK;
`endif
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
    end else if (do_entry) begin
      mepc         <= (is_irq ? irq_pc : trap_pc) & ALIGN_MASK;
      mcause       <= XLEN'(cause);
      mtval        <= is_irq ? '0 : trap_tval;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
      mstatus_mpp  <= privilege;
      privilege    <= PRIV_M;
    end else if (do_mret) begin
      privilege    <= mstatus_mpp;
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
      mstatus_mpp  <= PRIV_U;
    end else if (csr.csr_we) begin
      case (csr.csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie  <= csr.csr_wdata[MSTATUS_MIE];
          mstatus_mpie <= csr.csr_wdata[MSTATUS_MPIE];
          mstatus_mpp  <= csr.csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
        end
        CSR_MIE:    mie_meie <= csr.csr_wdata[MIE_MEIE];
`ifdef TRAP_UNIT_VECTORED_EN
        CSR_MTVEC:  mtvec    <= csr.csr_wdata;
`else
        CSR_MTVEC:  mtvec    <= csr.csr_wdata & ALIGN_MASK;
`endif
        CSR_MEPC:   mepc     <= csr.csr_wdata & ALIGN_MASK;
        CSR_MCAUSE: mcause   <= csr.csr_wdata;
        CSR_MTVAL:  mtval    <= csr.csr_wdata;
        default: ;
      endcase
    end
  end

  // Combinational CSR read; unimplemented bits and unowned addresses read 0.
  always_comb begin
    csr.csr_rdata = '0;
    csr.csr_hit   = 1'b1;
    case (csr.csr_addr)
      CSR_MSTATUS: begin
        csr.csr_rdata[MSTATUS_MIE]                   = mstatus_mie;
        csr.csr_rdata[MSTATUS_MPIE]                  = mstatus_mpie;
        csr.csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mstatus_mpp;
      end
      CSR_MIE:    csr.csr_rdata[MIE_MEIE] = mie_meie;
      CSR_MTVEC:  csr.csr_rdata = mtvec;
      CSR_MEPC:   csr.csr_rdata = mepc;
      CSR_MCAUSE: csr.csr_rdata = mcause;
      CSR_MTVAL:  csr.csr_rdata = mtval;
      CSR_MIP:    csr.csr_rdata[MIP_MEIP] = meip;
      default:    csr.csr_hit = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: directed self-checking bench for trap_unit. Inputs are driven
// 1ns after the rising edge and outputs are checked before the next one.
// When built with TRAP_UNIT_VECTORED_EN the vectored-mode steps run as well.
module tb_trap_unit;
  import trap_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trap_illegal_instr, trap_csr_access_violation;
  logic        trap_instr_addr_misaligned, trap_load_store_misaligned;
  logic [31:0] trap_pc, trap_tval, irq_pc, redirect_pc;
  logic        gpio0_irq, gpio1_irq, mret_valid;
  logic        flush_trap, redirect_valid;
  logic [1:0]  privilege;

  int checks   = 0;
  int failures = 0;

  trap_unit_if #(.XLEN(32)) csr_bus ();

  trap_unit #(.XLEN(32), .RESET_MTVEC(32'h0000_0100)) dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .trap_illegal_instr         (trap_illegal_instr),
    .trap_csr_access_violation  (trap_csr_access_violation),
    .trap_instr_addr_misaligned (trap_instr_addr_misaligned),
    .trap_load_store_misaligned (trap_load_store_misaligned),
    .trap_pc                    (trap_pc),
    .trap_tval                  (trap_tval),
    .gpio0_irq                  (gpio0_irq),
    .gpio1_irq                  (gpio1_irq),
    .irq_pc                     (irq_pc),
    .mret_valid                 (mret_valid),
    .csr                        (csr_bus),
    .flush_trap                 (flush_trap),
    .redirect_valid             (redirect_valid),
    .redirect_pc                (redirect_pc),
    .privilege                  (privilege)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ill, input logic csrv, input logic iam,
                               input logic lsm, input logic [31:0] pc,
                               input logic [31:0] tval);
    trap_illegal_instr         = ill;
    trap_csr_access_violation  = csrv;
    trap_instr_addr_misaligned = iam;
    trap_load_store_misaligned = lsm;
    trap_pc                    = pc;
    trap_tval                  = tval;
  endtask

  task automatic csrWrite(input logic [11:0] addr, input logic [31:0] data);
    csr_bus.csr_we    = 1'b1;
    csr_bus.csr_addr  = addr;
    csr_bus.csr_wdata = data;
    tick();
    csr_bus.csr_we    = 1'b0;
  endtask

  task automatic csrCheck(input string tag, input logic [11:0] addr,
                          input logic [31:0] expected);
    csr_bus.csr_addr = addr;
    #1;
    checkOutput(tag, csr_bus.csr_rdata, expected);
  endtask

  task automatic checkRedirect(input string tag, input logic exp_flush,
                               input logic [31:0] exp_pc);
    checkOutput({tag, "_flush"}, 32'(flush_trap), 32'(exp_flush));
    checkOutput({tag, "_rvalid"}, 32'(redirect_valid), 32'(exp_flush));
    checkOutput({tag, "_rpc"}, redirect_pc, exp_pc);
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    gpio0_irq = 1'b0;
    gpio1_irq = 1'b0;
    irq_pc    = 32'h0;
    mret_valid = 1'b0;
    csr_bus.csr_we    = 1'b0;
    csr_bus.csr_addr  = 12'h000;
    csr_bus.csr_wdata = 32'h0;

    // Reset state
    tick();
    tick();
    checkRedirect("reset", 1'b0, 32'h0);
    checkOutput("reset_priv", 32'(privilege), 32'h3);
    csrCheck("reset_mtvec", CSR_MTVEC, 32'h100);
    csrCheck("reset_mstatus", CSR_MSTATUS, 32'h0);
    checkOutput("hit_mtvec", 32'(csr_bus.csr_hit), 32'h1);
    csrCheck("unowned_rdata", 12'h123, 32'h0);
    checkOutput("unowned_hit", 32'(csr_bus.csr_hit), 32'h0);
    reset_n = 1'b1;
    tick();

    // Illegal instruction -> handler at mtvec, one cycle later
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'hDEAD);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkRedirect("ill", 1'b1, 32'h100);
    checkOutput("ill_priv", 32'(privilege), 32'h3);
    csrCheck("ill_mepc", CSR_MEPC, 32'h40);
    csrCheck("ill_mcause", CSR_MCAUSE, 32'h1);
    csrCheck("ill_mtval", CSR_MTVAL, 32'hDEAD);
    csrCheck("ill_mstatus", CSR_MSTATUS, 32'h1800);
    tick();
    checkRedirect("ill_done", 1'b0, 32'h0);

    // Illegal + load/store misaligned together; new flag during flush ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h11);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h99C, 32'h22);
    csrCheck("prio_mcause", CSR_MCAUSE, 32'h1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkRedirect("flush_ignore", 1'b0, 32'h0);
    csrCheck("flush_ignore_mcause", CSR_MCAUSE, 32'h1);
    csrCheck("flush_ignore_mepc", CSR_MEPC, 32'h80);

    // Interrupt masked by MIE = 0
    csrWrite(CSR_MSTATUS, 32'h0);
    csrWrite(CSR_MIE, 32'h800);
    irq_pc    = 32'h88;
    gpio1_irq = 1'b1;
    csrCheck("mip_meip", CSR_MIP, 32'h800);
    tick();
    checkRedirect("irq_masked", 1'b0, 32'h0);
    gpio1_irq = 1'b0;
    csrWrite(CSR_MIP, 32'h0);
    gpio1_irq = 1'b1;
    csrCheck("mip_readonly", CSR_MIP, 32'h800);
    gpio1_irq = 1'b0;

    // Interrupt taken with MIE = 1, MEIE = 1
    csrWrite(CSR_MSTATUS, 32'h8);
    gpio1_irq = 1'b1;
    tick();
    gpio1_irq = 1'b0;
    checkRedirect("irq", 1'b1, 32'h100);
    csrCheck("irq_mcause", CSR_MCAUSE, 32'h8000_000B);
    csrCheck("irq_mepc", CSR_MEPC, 32'h88);
    csrCheck("irq_mtval", CSR_MTVAL, 32'h0);
    csrCheck("irq_mstatus", CSR_MSTATUS, 32'h1880);
    tick();

    // mret back to user mode
    csrWrite(CSR_MEPC, 32'h204);
    csrCheck("mepc_rb", CSR_MEPC, 32'h204);
    csrWrite(CSR_MEPC, 32'h207);
    csrCheck("mepc_align", CSR_MEPC, 32'h204);
    csrWrite(CSR_MSTATUS, 32'h80);
    mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    checkRedirect("mret", 1'b1, 32'h204);
    checkOutput("mret_priv", 32'(privilege), 32'h0);
    csrCheck("mret_mstatus", CSR_MSTATUS, 32'h88);
    tick();
    checkRedirect("mret_done", 1'b0, 32'h0);

    // Trap from U mode; CSR write in the entry cycle is dropped
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h1234);
    csr_bus.csr_we    = 1'b1;
    csr_bus.csr_addr  = CSR_MTVAL;
    csr_bus.csr_wdata = 32'h5555;
    tick();
    csr_bus.csr_we = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkRedirect("utrap", 1'b1, 32'h100);
    checkOutput("utrap_priv", 32'(privilege), 32'h3);
    csrCheck("utrap_mtval", CSR_MTVAL, 32'h1234);
    csrCheck("utrap_mstatus", CSR_MSTATUS, 32'h80);
    tick();

    // mtvec mode bits
    csrWrite(CSR_MTVEC, 32'h101);
`ifdef TRAP_UNIT_VECTORED_EN
    csrCheck("mtvec_vec_rb", CSR_MTVEC, 32'h101);
    csrWrite(CSR_MSTATUS, 32'h8);
    irq_pc    = 32'h40;
    gpio0_irq = 1'b1;
    tick();
    gpio0_irq = 1'b0;
    checkRedirect("vec_irq", 1'b1, 32'h12C);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h60, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkRedirect("vec_sync", 1'b1, 32'h100);
    tick();
`else
    csrCheck("mtvec_direct_rb", CSR_MTVEC, 32'h100);
`endif

    // Async reset during ENTER_FLUSH
    csrWrite(CSR_MTVEC, 32'h200);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkRedirect("pre_rst", 1'b1, 32'h200);
    #2;
    reset_n = 1'b0;
    #1;
    checkRedirect("async_rst", 1'b0, 32'h0);
    checkOutput("async_rst_priv", 32'(privilege), 32'h3);
    csrCheck("async_rst_mtvec", CSR_MTVEC, 32'h100);
    csrCheck("async_rst_mepc", CSR_MEPC, 32'h0);
    csrCheck("async_rst_mcause", CSR_MCAUSE, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checkRedirect("post_rst", 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_unit.md
Name: trap_unit

Overview:
- Consumes the synchronous trap flags and GPIO interrupt lines raised by the pipeline.
- Arbitrates them and performs machine-mode trap entry: latches mepc/mcause/mtval and updates mstatus/privilege.
- Drives a one-cycle flush plus PC redirect to the handler.
- Executes mret as the return path.
- Owns the M-mode trap CSRs and exposes a CSR read/write port to the csr block.

Parameters:
- XLEN, 32, datapath width.
- RESET_MTVEC, 32'h0000_0100, mtvec value after reset.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- trap_illegal_instr  input  1  illegal instruction, synchronous.
- trap_csr_access_violation  input  1  CSR privilege violation.
- trap_instr_addr_misaligned  input  1  fetch target misaligned.
- trap_load_store_misaligned  input  1  data address misaligned.
- trap_pc  input  XLEN  PC of the faulting instruction.
- trap_tval  input  XLEN  faulting address or instruction bits.
- gpio0_irq, gpio1_irq  input  1 each  level-sensitive external interrupts.
- irq_pc  input  XLEN  PC of the oldest unretired instruction (resume point).
- mret_valid  input  1  mret in EX, qualified by the pipeline.
- csr_we  input  1  CSR write strobe.
- csr_addr  input  12  CSR address.
- csr_wdata  input  XLEN  CSR write data.
- csr_rdata  output  XLEN  combinational read data; 0 for unowned addresses.
- csr_hit  output  1  csr_addr is owned by this block.
- flush_trap  output  1  flush IF/ID, ID/EX and EX/MEM.
- redirect_valid  output  1  load redirect_pc into the PC.
- redirect_pc  output  XLEN  handler or return address.
- privilege  output  2  current privilege level.

Behaviour:
- Cause codes, priority high→low:
  - trap_illegal_instr = 1
  - trap_csr_access_violation = 2
  - trap_instr_addr_misaligned = 3
  - trap_load_store_misaligned = 4
  - external interrupt = 32'h8000_000B, lowest priority.
- Owned CSRs:
  - mstatus 0x300: only MIE[3], MPIE[7], MPP[12:11] implemented; other bits read 0.
  - mie 0x304: MEIE[11] only.
  - mtvec 0x305: low 2 bits read 0 unless VECTORED_EN.
  - mepc 0x341: bits[1:0] forced to 0.
  - mcause 0x342, mtval 0x343.
  - mip 0x344: MEIP[11] = gpio0_irq | gpio1_irq; read-only, writes ignored.
- FSM states: IDLE, ENTER_FLUSH, RET_FLUSH.
- IDLE, any sync trap flag high:
  - At the edge: mepc ← trap_pc, mcause ← code, mtval ← trap_tval, MPIE ← MIE, MIE ← 0, MPP ← privilege, privilege ← 2'b11.
  - Next state ENTER_FLUSH.
- IDLE, no sync trap, MIE & MEIE & MEIP: same entry sequence with mepc ← irq_pc and mtval ← 0.
- IDLE, mret_valid and no trap/interrupt:
  - At the edge: privilege ← MPP, MIE ← MPIE, MPIE ← 1, MPP ← 2'b00.
  - Next state RET_FLUSH.
- ENTER_FLUSH (exactly 1 cycle): flush_trap = 1, redirect_valid = 1, redirect_pc = {mtvec[31:2], 2'b00}; then IDLE.
- RET_FLUSH (exactly 1 cycle): flush_trap = 1, redirect_valid = 1, redirect_pc = mepc; then IDLE.
- Latency: trap flag to redirect is 1 cycle, i.e. redirect is visible in the cycle after the flag.
- All trap/interrupt/mret inputs are ignored in ENTER_FLUSH and RET_FLUSH; they belong to flushed instructions.
- Simultaneous events:
  - A sync trap beats an interrupt, which beats mret.
  - A CSR write in the same cycle as trap entry or mret is dropped.
  - A CSR write in other cycles updates at the edge; csr_rdata reflects it from the next cycle.
- Reset (async, any state) sets:
  - state IDLE, privilege 2'b11;
  - mstatus 0, mie 0, mepc 0, mcause 0, mtval 0;
  - mtvec RESET_MTVEC;
  - flush_trap 0, redirect_valid 0, redirect_pc 0.

Optional Feature:
- TRAP_UNIT_VECTORED_EN defined:
  - mtvec[1:0] is writable.
  - When mtvec[1:0] == 2'b01 and the cause is an interrupt, redirect_pc = base + 4·11 = base + 44.
  - Synchronous traps always use base.
- Undefined: mtvec[1:0] is hardwired to 0 (direct mode only).

Decomposition:
- Shared package holds:
  - cause constants (CAUSE_ILLEGAL … CAUSE_MEXT_IRQ);
  - CSR address constants;
  - mstatus bit indices;
  - privilege encodings PRIV_U = 2'b00, PRIV_M = 2'b11;
  - FSM state typedef.
- One sub-module, trap_prio_enc: combinational priority encoder producing take_trap and cause.

Test Plan:
- Illegal instruction at trap_pc = 0x0000_0040, mtvec = 0x100 → next cycle flush_trap = 1, redirect_pc = 0x100; mepc = 0x40, mcause = 1, privilege = 2'b11.
- Illegal and load/store misaligned raised in the same cycle → mcause = 1; a second trap flag during ENTER_FLUSH is ignored.
- MIE = 1, MEIE = 1, gpio1_irq high, irq_pc = 0x88 → mcause = 0x8000_000B, mepc = 0x88, MIE = 0, MPIE = 1. With MIE = 0 → no trap taken.
- Write mepc = 0x204 (read back 0x204), MPP = 00, MPIE = 1; then mret_valid → redirect_pc = 0x204, privilege = 2'b00, MIE = 1.
- Deassert reset_n during ENTER_FLUSH → outputs clear immediately without waiting for a clock edge; mtvec = RESET_MTVEC.
- With TRAP_UNIT_VECTORED_EN, mtvec = 0x101 → interrupt redirects to 0x12C; an illegal-instruction trap redirects to 0x100.
